// File: rtl/bus_pkg.sv
// Shared bus constants and destination-field helper for bus device FIFOs.
package bus_pkg;
  localparam int PCKG_SZ = 16;
  localparam int DEST_W = 8;
  localparam int MAX_W = 64;
  localparam logic [DEST_W-1:0] BROADCAST = 8'hFF;

  // Destination sits in the top DEST_W bits of an sz-bit packet
  function automatic logic [DEST_W-1:0] get_dest(input logic [MAX_W-1:0] pkt, input int sz);
    return DEST_W'(pkt >> (sz - DEST_W));
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count and registered overflow pulse.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [WIDTH-1:0] din,
  input  logic             rd,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             ovf
);
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0] wptr, rptr;
  logic do_wr, do_rd;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  // A read frees a slot in the same cycle, so a full FIFO still accepts a write alongside it
  assign do_rd = rd & ~empty;
  assign do_wr = wr & (~full | do_rd);
  assign dout  = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
      count <= count + CW'(do_wr) - CW'(do_rd);
      ovf   <= wr & ~do_wr;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr && !reset) mem[wptr] <= din;
  end
endmodule

// File: rtl/bus_dev_fifo.sv
// Bus device endpoint: host TX queue toward the bus, address-filtered RX queue from the bus.
module bus_dev_fifo import bus_pkg::*; #(
  parameter int pckg_sz = PCKG_SZ,
  parameter int depth = 8,
  parameter logic [DEST_W-1:0] id = 8'h00,
  parameter logic [DEST_W-1:0] broadcast = BROADCAST,
  localparam int CW = $clog2(depth + 1)
)(
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [pckg_sz-1:0] wr_data,
  output logic               tx_full,
  output logic               tx_ovf,
  output logic               pndng,
  output logic [pckg_sz-1:0] D_pop,
  input  logic               pop,
  input  logic               push,
  input  logic [pckg_sz-1:0] D_push,
  input  logic               rd_en,
  output logic [pckg_sz-1:0] rd_data,
  output logic               rx_valid,
  output logic               rx_drop,
  output logic [CW-1:0]      tx_count,
  output logic [CW-1:0]      rx_count
);
  logic [DEST_W-1:0] dest;
  logic accept, tx_empty, rx_empty, rx_full_unused;

  assign dest   = get_dest(MAX_W'(D_push), pckg_sz);
  assign accept = push & ((dest == id) | (dest == broadcast));

  sync_fifo #(.WIDTH(pckg_sz), .DEPTH(depth)) u_tx (
    .clk(clk), .reset(reset),
    .wr(wr_en), .din(wr_data), .rd(pop), .dout(D_pop),
    .full(tx_full), .empty(tx_empty), .count(tx_count), .ovf(tx_ovf)
  );

  sync_fifo #(.WIDTH(pckg_sz), .DEPTH(depth)) u_rx (
    .clk(clk), .reset(reset),
    .wr(accept), .din(D_push), .rd(rd_en), .dout(rd_data),
    .full(rx_full_unused), .empty(rx_empty), .count(rx_count), .ovf(rx_drop)
  );

  assign pndng    = ~tx_empty;
  assign rx_valid = ~rx_empty;
endmodule

// File: tb/tb_bus_dev_fifo.sv
// Directed bench for bus_dev_fifo with queue-based scoreboard of both FIFOs.
module tb_bus_dev_fifo;
  localparam int W = 16;
  localparam int D = 8;
  localparam int CW = $clog2(D + 1);

  logic clk = 1'b0;
  logic reset, wr_en, pop, push, rd_en;
  logic [W-1:0] wr_data, D_push, D_pop, rd_data;
  logic tx_full, tx_ovf, pndng, rx_valid, rx_drop;
  logic [CW-1:0] tx_count, rx_count;

  int compared = 0;
  int mismatched = 0;
  logic [W-1:0] txq[$];
  logic [W-1:0] rxq[$];
  logic exp_ovf, exp_drop;

  bus_dev_fifo #(.pckg_sz(W), .depth(D), .id(8'h02), .broadcast(8'hFF)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .tx_full(tx_full), .tx_ovf(tx_ovf), .pndng(pndng), .D_pop(D_pop), .pop(pop),
    .push(push), .D_push(D_push), .rd_en(rd_en), .rd_data(rd_data),
    .rx_valid(rx_valid), .rx_drop(rx_drop), .tx_count(tx_count), .rx_count(rx_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".tx_count"}, 32'(tx_count), 32'(txq.size()));
    chk({tag, ".tx_full"},  32'(tx_full),  32'(txq.size() == D));
    chk({tag, ".pndng"},    32'(pndng),    32'(txq.size() != 0));
    chk({tag, ".D_pop"},    32'(D_pop),    txq.size() != 0 ? 32'(txq[0]) : 32'h0);
    chk({tag, ".tx_ovf"},   32'(tx_ovf),   32'(exp_ovf));
    chk({tag, ".rx_count"}, 32'(rx_count), 32'(rxq.size()));
    chk({tag, ".rx_valid"}, 32'(rx_valid), 32'(rxq.size() != 0));
    chk({tag, ".rd_data"},  32'(rd_data),  rxq.size() != 0 ? 32'(rxq[0]) : 32'h0);
    chk({tag, ".rx_drop"},  32'(rx_drop),  32'(exp_drop));
  endtask

  // One clock of stimulus: model the expected effect, drive, advance, compare
  task automatic step(input string tag, input logic w, input logic [W-1:0] wd, input logic p,
                      input logic ps, input logic [W-1:0] pd, input logic r);
    logic do_pop, do_wr, acc, do_rd, do_push;
    logic [W-1:0] popped;
    do_pop = p && txq.size() > 0;
    do_wr  = w && (txq.size() < D || do_pop);
    acc    = ps && (pd[W-1:W-8] == 8'h02 || pd[W-1:W-8] == 8'hFF);
    do_rd  = r && rxq.size() > 0;
    do_push = acc && (rxq.size() < D || do_rd);
    wr_en = w; wr_data = wd; pop = p; push = ps; D_push = pd; rd_en = r;
    if (do_pop) begin
      popped = txq.pop_front();
      chk({tag, ".popped"}, 32'(D_pop), 32'(popped));
    end
    if (do_rd) begin
      popped = rxq.pop_front();
      chk({tag, ".read"}, 32'(rd_data), 32'(popped));
    end
    if (do_wr) txq.push_back(wd);
    if (do_push) rxq.push_back(pd);
    exp_ovf  = w && !do_wr;
    exp_drop = acc && !do_push;
    @(posedge clk); #1;
    wr_en = 0; pop = 0; push = 0; rd_en = 0;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag, input logic noisy);
    reset = 1;
    wr_en = noisy; wr_data = 16'h0299; pop = noisy;
    push = noisy; D_push = 16'h0277; rd_en = noisy;
    @(posedge clk); #1;
    reset = 0; wr_en = 0; pop = 0; push = 0; rd_en = 0;
    txq.delete(); rxq.delete();
    exp_ovf = 0; exp_drop = 0;
    check_all(tag);
  endtask

  initial begin
    reset = 1; wr_en = 0; pop = 0; push = 0; rd_en = 0; wr_data = '0; D_push = '0;
    exp_ovf = 0; exp_drop = 0;
    @(posedge clk); #1;
    do_reset("rst0", 1'b0);

    // basic TX order and empty zeroing
    step("w1", 1, 16'h01AA, 0, 0, 0, 0);
    step("w2", 1, 16'h02BB, 0, 0, 0, 0);
    step("p1", 0, 0, 1, 0, 0, 0);
    step("p2", 0, 0, 1, 0, 0, 0);
    step("pop_empty", 0, 0, 1, 0, 0, 0);
    step("wp_empty", 1, 16'h0C0C, 1, 0, 0, 0);
    step("p3", 0, 0, 1, 0, 0, 0);

    // TX full, overflow pulse, write+pop while full
    for (int i = 0; i < D; i++) step("fill", 1, 16'(16'h0300 + i), 0, 0, 0, 0);
    step("ovf", 1, 16'h0EEE, 0, 0, 0, 0);
    step("ovf_gone", 0, 0, 0, 0, 0, 0);
    step("wp_full", 1, 16'h0ABC, 1, 0, 0, 0);
    for (int i = 0; i < D; i++) step("drain", 0, 0, 1, 0, 0, 0);

    // RX address filter and order
    step("rx1", 0, 0, 0, 1, 16'h02C3, 0);
    step("rx2", 0, 0, 0, 1, 16'h05C4, 0);
    step("rx3", 0, 0, 0, 1, 16'hFFC5, 0);
    step("rd1", 0, 0, 0, 0, 0, 1);
    step("rd2", 0, 0, 0, 0, 0, 1);
    step("rd_empty", 0, 0, 0, 0, 0, 1);

    // RX full: drop without read, accept with read
    for (int i = 0; i < D; i++) step("rxfill", 0, 0, 0, 1, 16'(16'h0240 + i), 0);
    step("rxdrop", 0, 0, 0, 1, 16'h0211, 0);
    step("rxdrop_gone", 0, 0, 0, 0, 0, 0);
    step("rx_pr_full", 0, 0, 0, 1, 16'h0211, 1);
    for (int i = 0; i < D; i++) step("rxdrain", 0, 0, 0, 0, 0, 1);

    // reset mid-operation, with active inputs during the reset cycle
    for (int i = 0; i < 3; i++) step("pre_tx", 1, 16'(16'h0400 + i), 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) step("pre_rx", 0, 0, 0, 1, 16'(16'hFF50 + i), 0);
    do_reset("rst_mid", 1'b1);

    // pointer wrap through 20 write/pop pairs
    for (int i = 0; i < 20; i++) step("wrap", 1, 16'(16'h1000 + 16'(i) * 16'h0101), i > 0, 0, 0, 0);
    step("wrap_last", 0, 0, 1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/bus_dev_fifo.md
BUS_DEV_FIFO -- requirements
Module: bus_dev_fifo

Interface
REQ-001 The block SHALL have parameter pckg_sz, default 16, giving the packet width in bits.
REQ-002 The block SHALL have parameter depth, default 8, giving the entries per FIFO; it is a power of two and at least 2.
REQ-003 The block SHALL have parameter id, default 0, giving this device's 8-bit address.
REQ-004 The block SHALL have parameter broadcast, default 8'hFF, giving the broadcast address.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port wr_en, input, 1 bit: host write request to the TX FIFO.
REQ-008 The block SHALL have port wr_data, input, pckg_sz bits: host packet to transmit.
REQ-009 The block SHALL have port tx_full, output, 1 bit: asserted when the TX FIFO holds depth entries.
REQ-010 The block SHALL have port tx_ovf, output, 1 bit: one-cycle pulse when a write is dropped.
REQ-011 The block SHALL have port pndng, output, 1 bit: asserted while the TX FIFO is non-empty (bus side).
REQ-012 The block SHALL have port D_pop, output, pckg_sz bits: the TX head packet offered to the bus.
REQ-013 The block SHALL have port pop, input, 1 bit: bus consumes the TX head this cycle.
REQ-014 The block SHALL have port push, input, 1 bit: bus delivers D_push this cycle.
REQ-015 The block SHALL have port D_push, input, pckg_sz bits: packet delivered by the bus.
REQ-016 The block SHALL have port rd_en, input, 1 bit: host read of the RX head.
REQ-017 The block SHALL have port rd_data, output, pckg_sz bits: the RX head packet (show-ahead).
REQ-018 The block SHALL have port rx_valid, output, 1 bit: asserted while the RX FIFO is non-empty.
REQ-019 The block SHALL have port rx_drop, output, 1 bit: one-cycle pulse when an accepted packet is lost because the RX FIFO is full.
REQ-020 The block SHALL have ports tx_count and rx_count, outputs, $clog2(depth+1) bits each: current occupancy of each FIFO.

Function
REQ-021 The destination field SHALL be packet bits [pckg_sz-1:pckg_sz-8].
REQ-022 When wr_en=1 and the TX FIFO is not full, the block SHALL enqueue wr_data; pndng and D_pop SHALL reflect the new entry on the next cycle.
REQ-023 When wr_en=1 while the TX FIFO is full and pop=0, the block SHALL drop the write and pulse tx_ovf for exactly one cycle.
REQ-024 When pop=1 and pndng=1, the block SHALL dequeue the head; a pop with pndng=0 SHALL be ignored with no state change.
REQ-025 When wr_en=1 and pop=1 occur together while the FIFO is full, both SHALL take effect, tx_count SHALL stay at depth, and tx_ovf SHALL remain 0.
REQ-026 When wr_en=1 and pop=1 occur together while the FIFO is empty, only the write SHALL take effect.
REQ-027 D_pop SHALL be 0 whenever pndng=0; rd_data SHALL be 0 whenever rx_valid=0.
REQ-028 On push=1, the block SHALL accept D_push only if its destination equals id or broadcast; non-matching packets SHALL be discarded silently.
REQ-029 An accepted packet SHALL be enqueued in the RX FIFO and become visible on rd_data and rx_valid the next cycle.
REQ-030 When the RX FIFO is full and no read occurs that cycle, an accepted packet SHALL be dropped and rx_drop SHALL pulse for one cycle.
REQ-031 The same full/empty simultaneity rules as REQ-025 and REQ-026 SHALL apply to push with rd_en.
REQ-032 Read and write pointers SHALL wrap modulo depth.
REQ-033 Counts SHALL change by -1, 0 or +1 per cycle and never exceed depth.
REQ-034 Packet order SHALL be preserved in both FIFOs.

Reset
REQ-035 While reset=1 at a clk edge, the block SHALL clear all pointers and counts.
REQ-036 After reset, pndng, tx_full, tx_ovf, rx_valid and rx_drop SHALL be 0, and D_pop and rd_data SHALL be 0.
REQ-037 Storage arrays SHALL NOT be reset.
REQ-038 A reset asserted mid-operation SHALL discard all queued packets, and inputs in the reset cycle SHALL be ignored.

Structure
REQ-039 A shared package bus_pkg SHALL hold the pckg_sz default, the broadcast constant, the destination-field width (8), and a function returning the destination of a packet.
REQ-040 Both queues SHALL be instances of one sub-module, sync_fifo: show-ahead, parameterised by width and depth, with full/empty/count outputs and an internal overflow indication.

Verification
REQ-041 Reset, then write 16'h01AA, 16'h02BB -> pndng=1 next cycle, D_pop=16'h01AA; after one pop, D_pop=16'h02BB; after a second pop, pndng=0 and D_pop=0.
REQ-042 Write 8 packets with no pop -> tx_full=1, tx_count=8; a 9th write -> tx_ovf pulses one cycle, tx_count stays 8; write+pop in the same cycle while full -> tx_count=8, tx_ovf=0.
REQ-043 With id=2, push 16'h02C3, 16'h05C4 and 16'hFFC5 -> rx_count=2 and the read order is 16'h02C3 then 16'hFFC5.
REQ-044 With the RX FIFO full (8 entries), push 16'h0211 with rd_en=0 -> rx_drop pulses; repeat with rd_en=1 -> packet is accepted, rx_count=8, rx_drop=0.
REQ-045 With 3 TX and 2 RX entries queued, assert reset for one cycle -> next cycle all counts are 0, pndng=0, rx_valid=0, and D_pop and rd_data are 0.
REQ-046 Perform 20 write/pop pairs through the depth-8 TX FIFO -> pointers wrap and the output sequence equals the input sequence exactly.
